// File: rtl/seq_signmag_multiplier.sv
// Sequential shift-add multiplier for WIDTH-bit sign-magnitude operands.
// One magnitude bit is consumed per RUN cycle; the product registers change only on entry to DONE.
module seq_signmag_multiplier #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic                 sign,
    output logic                 zflag,
    output logic [2*WIDTH-3:0]   result
);
    localparam int MW = WIDTH - 1;
    localparam int PW = 2 * WIDTH - 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mag_a_q, mag_a_d;
    logic [MW-1:0]   mag_b_q, mag_b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sgn_q, sgn_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sign_q, sign_d;
    logic            zflag_q, zflag_d;
    logic [PW-1:0]   result_q, result_d;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_sum;
    logic [MW-1:0]   mag_a_shift;
    logic            last_iter;

    always_comb begin
        state_d     = state_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sgn_d       = sgn_q;
        busy_d      = busy_q;
        done_d      = done_q;
        sign_d      = sign_q;
        zflag_d     = zflag_q;
        result_d    = result_q;

        addend      = mag_a_q[0] ? (PW'(mag_b_q) << count_q) : '0;
        acc_sum     = acc_q + addend;
        mag_a_shift = mag_a_q >> 1;
        last_iter   = (count_q == CW'(WIDTH - 2)) ||
                      ((EARLY_EXIT != 0) && (mag_a_shift == '0));

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    mag_a_d = multiplier[MW-1:0];
                    mag_b_d = multiplicand[MW-1:0];
                    sgn_d   = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
                    acc_d   = '0;
                    count_d = '0;
                    // A zero multiplier with early exit completes immediately with +0.
                    if ((EARLY_EXIT != 0) && (multiplier[MW-1:0] == '0)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                        zflag_d  = 1'b1;
                        sign_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d   = acc_sum;
                mag_a_d = mag_a_shift;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = acc_sum;
                    zflag_d  = (acc_sum == '0);
                    sign_d   = sgn_q & (acc_sum != '0);
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            sgn_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            zflag_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sgn_q    <= sgn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sign_q   <= sign_d;
            zflag_q  <= zflag_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sign   = sign_q;
    assign zflag  = zflag_q;
    assign result = result_q;

endmodule
